branch_recovery_controller: RTL and testbench



---
 rtl/branch_ctrl_pkg.sv | 33 +++
 rtl/sat_counter.sv | 29 ++
 rtl/branch_recovery_controller.sv | 153 +++++++++++++++
 tb/tb_branch_recovery_controller.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_ctrl_pkg.sv
// Shared types and defaults for the branch recovery controller.
package branch_ctrl_pkg;

    // Controller FSM states.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_e;

    // Which source (if any) is redirecting fetch this cycle.
    typedef enum logic [1:0] {
        SRC_NONE    = 2'd0,
        SRC_MISPRED = 2'd1,
        SRC_JUMP    = 2'd2
    } redir_src_e;

    localparam int DEF_FLUSH_CYCLES = 2;
    localparam int DEF_CNT_W        = 16;

    // The mispredicted EX instruction is older than the ID jump, so it wins.
    function automatic redir_src_e select_source(input logic mispred, input logic jump);
        redir_src_e src;
        if (mispred) begin
            src = SRC_MISPRED;
        end else if (jump) begin
            src = SRC_JUMP;
        end else begin
            src = SRC_NONE;
        end
        return src;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; never wraps past all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Count register: clear has priority, increment stops at the maximum value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (inc && (count_r != {W{1'b1}})) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/branch_recovery_controller.sv
// Arbitrates mispredict/jump redirects, drives a registered fetch redirect,
// times the IF/ID and ID/EX flushes and keeps branch statistics.
module branch_recovery_controller
    import branch_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Wrong,
    input  logic [31:0]      PC_reverse,
    input  logic             ID_EX_Branch,
    input  logic             Jump,
    input  logic [31:0]      Jump_Target,
    output logic             PC_redirect_valid,
    output logic [31:0]      PC_redirect,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             Busy,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    state_e      state_r;
    state_e      state_nx_s;
    logic [2:0]  flush_cnt_r;
    logic [2:0]  flush_cnt_nx_s;
    logic [31:0] pc_redirect_r;
    logic [31:0] pc_redirect_nx_s;
    logic        redirect_valid_r;
    logic        redirect_valid_nx_s;
    logic        if_id_flush_r;
    logic        if_id_flush_nx_s;
    logic        id_ex_flush_r;
    logic        id_ex_flush_nx_s;
    logic        busy_r;
    logic        busy_nx_s;

    logic        mispred_s;
    redir_src_e  src_s;
    logic        branch_inc_s;
    logic        mispred_inc_s;

    // Events only count while IDLE; anything seen in FLUSH is a squashed instruction.
    always_comb begin
        mispred_s = Wrong & ID_EX_Branch;
        if (state_r == IDLE) begin
            src_s        = select_source(mispred_s, Jump);
            branch_inc_s = ID_EX_Branch;
        end else begin
            src_s        = SRC_NONE;
            branch_inc_s = 1'b0;
        end
        mispred_inc_s = (src_s == SRC_MISPRED);
    end

    // Next-state and next-output logic for the recovery FSM.
    always_comb begin
        state_nx_s          = state_r;
        flush_cnt_nx_s      = flush_cnt_r;
        pc_redirect_nx_s    = pc_redirect_r;
        redirect_valid_nx_s = 1'b0;
        if_id_flush_nx_s    = 1'b0;
        id_ex_flush_nx_s    = 1'b0;
        busy_nx_s           = 1'b0;
        case (state_r)
            IDLE: begin
                case (src_s)
                    SRC_MISPRED: begin
                        pc_redirect_nx_s    = PC_reverse;
                        redirect_valid_nx_s = 1'b1;
                        flush_cnt_nx_s      = FLUSH_LOAD;
                        state_nx_s          = FLUSH;
                        if_id_flush_nx_s    = 1'b1;
                        id_ex_flush_nx_s    = 1'b1;
                        busy_nx_s           = 1'b1;
                    end
                    SRC_JUMP: begin
                        // A jump only kills the wrong-path fetch in IF/ID.
                        pc_redirect_nx_s    = Jump_Target;
                        redirect_valid_nx_s = 1'b1;
                        if_id_flush_nx_s    = 1'b1;
                    end
                    default: begin
                        pc_redirect_nx_s = pc_redirect_r;
                    end
                endcase
            end
            FLUSH: begin
                if (flush_cnt_r <= 3'd1) begin
                    state_nx_s     = IDLE;
                    flush_cnt_nx_s = 3'd0;
                end else begin
                    flush_cnt_nx_s   = flush_cnt_r - 3'd1;
                    if_id_flush_nx_s = 1'b1;
                    id_ex_flush_nx_s = 1'b1;
                    busy_nx_s        = 1'b1;
                end
            end
            default: begin
                state_nx_s     = IDLE;
                flush_cnt_nx_s = 3'd0;
            end
        endcase
    end

    // State, flush counter and all registered control outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r          <= IDLE;
            flush_cnt_r      <= 3'd0;
            pc_redirect_r    <= 32'd0;
            redirect_valid_r <= 1'b0;
            if_id_flush_r    <= 1'b0;
            id_ex_flush_r    <= 1'b0;
            busy_r           <= 1'b0;
        end else begin
            state_r          <= state_nx_s;
            flush_cnt_r      <= flush_cnt_nx_s;
            pc_redirect_r    <= pc_redirect_nx_s;
            redirect_valid_r <= redirect_valid_nx_s;
            if_id_flush_r    <= if_id_flush_nx_s;
            id_ex_flush_r    <= id_ex_flush_nx_s;
            busy_r           <= busy_nx_s;
        end
    end

    assign PC_redirect_valid = redirect_valid_r;
    assign PC_redirect       = pc_redirect_r;
    assign IF_ID_Flush       = if_id_flush_r;
    assign ID_EX_Flush       = id_ex_flush_r;
    assign Busy              = busy_r;

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (branch_inc_s),
        .count (branch_count)
    );

    sat_counter #(.W(CNT_W)) u_mispred_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (mispred_inc_s),
        .count (mispredict_count)
    );

endmodule

// File: tb/tb_branch_recovery_controller.sv
// Scoreboard bench: the driver pushes expected redirects and per-cycle
// expectations from a high-level model; a monitor compares after each edge.
// A second instance with 3-bit counters exercises saturation.
module tb_branch_recovery_controller;

    localparam int FC      = 2;
    localparam int MAX_BIG = 65535;
    localparam int MAX_SML = 7;

    logic        clk = 1'b0;
    logic        reset;
    logic        Wrong;
    logic [31:0] PC_reverse;
    logic        ID_EX_Branch;
    logic        Jump;
    logic [31:0] Jump_Target;

    logic        PC_redirect_valid, IF_ID_Flush, ID_EX_Flush, Busy;
    logic [31:0] PC_redirect;
    logic [15:0] branch_count, mispredict_count;

    logic        s_valid, s_if, s_idex, s_busy;
    logic [31:0] s_pc;
    logic [2:0]  s_bc, s_mc;

    branch_recovery_controller #(.FLUSH_CYCLES(FC), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .Wrong(Wrong), .PC_reverse(PC_reverse),
        .ID_EX_Branch(ID_EX_Branch), .Jump(Jump), .Jump_Target(Jump_Target),
        .PC_redirect_valid(PC_redirect_valid), .PC_redirect(PC_redirect),
        .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush), .Busy(Busy),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    branch_recovery_controller #(.FLUSH_CYCLES(FC), .CNT_W(3)) dut_s (
        .clk(clk), .reset(reset), .Wrong(Wrong), .PC_reverse(PC_reverse),
        .ID_EX_Branch(ID_EX_Branch), .Jump(Jump), .Jump_Target(Jump_Target),
        .PC_redirect_valid(s_valid), .PC_redirect(s_pc),
        .IF_ID_Flush(s_if), .ID_EX_Flush(s_idex), .Busy(s_busy),
        .branch_count(s_bc), .mispredict_count(s_mc)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [31:0] redir_q[$];
    int          rem = 0;
    int          exp_bc = 0, exp_mc = 0, exp_bc_s = 0, exp_mc_s = 0;
    logic [31:0] exp_pc = 32'd0;
    bit          exp_valid = 1'b0, exp_if = 1'b0, exp_idex = 1'b0, exp_busy = 1'b0;
    bit          mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v, input int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    task automatic model_clear();
        redir_q.delete();
        rem = 0;
        exp_bc = 0; exp_mc = 0; exp_bc_s = 0; exp_mc_s = 0;
        exp_pc = 32'd0;
        exp_valid = 1'b0; exp_if = 1'b0; exp_idex = 1'b0; exp_busy = 1'b0;
    endtask

    // Drive one cycle of inputs and advance the model to what the outputs
    // must show after the coming rising edge.
    task automatic step(input bit w, input bit br, input logic [31:0] pcr,
                        input bit j, input logic [31:0] jt);
        bit idle, acc_mis, acc_jmp;
        @(negedge clk);
        Wrong = w; ID_EX_Branch = br; PC_reverse = pcr; Jump = j; Jump_Target = jt;
        idle = (rem == 0);
        acc_mis = idle && w && br;
        acc_jmp = idle && !acc_mis && j;
        if (idle && br) begin
            exp_bc   = sat_inc(exp_bc, MAX_BIG);
            exp_bc_s = sat_inc(exp_bc_s, MAX_SML);
        end
        if (acc_mis) begin
            rem = FC;
            exp_pc = pcr;
            redir_q.push_back(pcr);
            exp_mc   = sat_inc(exp_mc, MAX_BIG);
            exp_mc_s = sat_inc(exp_mc_s, MAX_SML);
        end else if (acc_jmp) begin
            exp_pc = jt;
            redir_q.push_back(jt);
        end else if (!idle) begin
            rem = rem - 1;
        end
        exp_valid = acc_mis || acc_jmp;
        exp_busy  = (rem > 0);
        exp_idex  = (rem > 0);
        exp_if    = (rem > 0) || acc_jmp;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, {31'd0, PC_redirect_valid}, 32'd0);
        check({tag, "_pc"}, PC_redirect, 32'd0);
        check({tag, "_ifid"}, {31'd0, IF_ID_Flush}, 32'd0);
        check({tag, "_idex"}, {31'd0, ID_EX_Flush}, 32'd0);
        check({tag, "_busy"}, {31'd0, Busy}, 32'd0);
        check({tag, "_bc"}, {16'd0, branch_count}, 32'd0);
        check({tag, "_mc"}, {16'd0, mispredict_count}, 32'd0);
        check({tag, "_small_mc"}, {29'd0, s_mc}, 32'd0);
    endtask

    // Asynchronous reset pulled between edges, checked before any clock edge.
    task automatic async_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        Wrong = 1'b0; ID_EX_Branch = 1'b0; Jump = 1'b0;
        model_clear();
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Monitor: compare every cycle shortly after the rising edge; redirect
    // pulses pop the scoreboard queue.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            check("valid", {31'd0, PC_redirect_valid}, {31'd0, exp_valid});
            check("if_id_flush", {31'd0, IF_ID_Flush}, {31'd0, exp_if});
            check("id_ex_flush", {31'd0, ID_EX_Flush}, {31'd0, exp_idex});
            check("busy", {31'd0, Busy}, {31'd0, exp_busy});
            check("pc_hold", PC_redirect, exp_pc);
            check("branch_count", {16'd0, branch_count}, 32'(exp_bc));
            check("mispredict_count", {16'd0, mispredict_count}, 32'(exp_mc));
            check("small_valid", {31'd0, s_valid}, {31'd0, exp_valid});
            check("small_busy", {31'd0, s_busy}, {31'd0, exp_busy});
            check("small_branch_count", {29'd0, s_bc}, 32'(exp_bc_s));
            check("small_mispredict_count", {29'd0, s_mc}, 32'(exp_mc_s));
            if (PC_redirect_valid) begin
                if (redir_q.size() > 0) begin
                    check("redirect_addr", PC_redirect, redir_q.pop_front());
                end else begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_redirect: got %h expected no pulse at %0t", PC_redirect, $time);
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        Wrong = 1'b0; ID_EX_Branch = 1'b0; Jump = 1'b0;
        PC_reverse = 32'd0; Jump_Target = 32'd0;
        model_clear();
        mon_en = 1'b1;
        #3;
        check_all_zero("reset_state");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Basic mispredict
        step(1'b1, 1'b1, 32'h0000_0040, 1'b0, 32'd0);
        idle_cycles(3);
        // Jump in IDLE
        step(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0100);
        idle_cycles(2);
        // Simultaneous mispredict and jump
        step(1'b1, 1'b1, 32'h0000_0080, 1'b1, 32'h0000_0200);
        idle_cycles(3);
        // Events during FLUSH ignored, first IDLE cycle accepted
        step(1'b1, 1'b1, 32'h0000_0300, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'h0000_0304, 1'b1, 32'h0000_0308);
        step(1'b1, 1'b1, 32'h0000_030c, 1'b1, 32'h0000_0310);
        step(1'b1, 1'b1, 32'h0000_0400, 1'b0, 32'd0);
        idle_cycles(3);
        // Reset in the middle of FLUSH, then a fresh mispredict
        step(1'b1, 1'b1, 32'h0000_0500, 1'b0, 32'd0);
        idle_cycles(1);
        async_reset();
        step(1'b1, 1'b1, 32'h0000_0040, 1'b0, 32'd0);
        idle_cycles(3);
        // Back-to-back jumps, then a mispredict right after a jump
        step(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0600);
        step(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0604);
        step(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0608);
        step(1'b1, 1'b1, 32'h0000_060c, 1'b0, 32'd0);
        idle_cycles(3);
        // Drive the 3-bit counters well past saturation
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b1, 32'h0000_1000 + 32'(k * 4), 1'b0, 32'd0);
            idle_cycles(2);
        end
        // Random traffic
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1, $urandom,
                 ($urandom_range(0, 3) == 0), $urandom);
        end
        idle_cycles(4);
        check("scoreboard_drained", 32'(redir_q.size()), 32'd0);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
